regram_arbiter: RTL and testbench

//  Shares the single-port 256x8 JTAG register RAM between a background scanner and a host port.
//  - Scanner: copies status bytes into the upper half (0x80-0xFF, FPGA->JTAG).
//  - Scanner: pulls config bytes from the lower half (0x00-0x7F, JTAG->FPGA) into the register bank.
//  - Host port: random-access req/ack port for an on-chip sequencer.

---
 rtl/regram_arbiter.sv | 228 ++++++++++++++++++++++
 tb/tb_regram_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regram_arbiter.sv
// regram_arbiter: arbitrates the single-port 256x8 JTAG register RAM between
// a background scanner and a random-access host port.
//   - Scanner, counter in 0x00-0x7F: RAM byte -> config bank (CFG_*).
//   - Scanner, counter in 0x80-0xFF: status bank byte (STS_*) -> RAM.
//   - Host: req/ack port; reads take 3 edges, writes take 2 edges.
// Optional feature: define REGRAM_ARB_WPROT_EN to block host writes to the
// upper half. A blocked write returns ACK_o together with ERR_o.
// Ports:
//   CK_i, ARST_i                       clock, async active-high reset
//   CK_EE_i                            scan tick (one scan slot per pulse)
//   REQ_i, WE_i, ADR_i, WDAT_i         host request
//   ACK_o, RDAT_o, ERR_o               host response
//   RAM_ADR_o, RAM_WE_o, RAM_WDAT_o    RAM command
//   RAM_RDAT_i                         RAM read data, 1-cycle latency
//   STS_SEL_o, STS_DAT_i               status bank select / data
//   CFG_WE_o, CFG_ADR_o, CFG_DAT_o     config bank write
//   SCAN_WRAP_o, SCAN_OVF_o            counter wrap pulse, sticky tick overflow
module regram_arbiter #(
    parameter int unsigned MAX_HOST_BURST = 4,
    parameter logic [7:0]  SCAN_BASE      = 8'h00
) (
    input  logic       CK_i,
    input  logic       ARST_i,
    input  logic       CK_EE_i,
    input  logic       REQ_i,
    input  logic       WE_i,
    input  logic [7:0] ADR_i,
    input  logic [7:0] WDAT_i,
    output logic       ACK_o,
    output logic [7:0] RDAT_o,
    output logic       ERR_o,
    output logic [7:0] RAM_ADR_o,
    output logic       RAM_WE_o,
    output logic [7:0] RAM_WDAT_o,
    input  logic [7:0] RAM_RDAT_i,
    output logic [6:0] STS_SEL_o,
    input  logic [7:0] STS_DAT_i,
    output logic       CFG_WE_o,
    output logic [6:0] CFG_ADR_o,
    output logic [7:0] CFG_DAT_o,
    output logic       SCAN_WRAP_o,
    output logic       SCAN_OVF_o
);

    localparam int unsigned BURST_W = $clog2(MAX_HOST_BURST + 1);

    typedef enum logic [2:0] {
        IDLE, H_RD, H_RDW, H_WR, SCAN_RD, SCAN_RDW, SCAN_ST, SCAN_WR
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           ctr_q, ctr_d;
    logic                 pending_q, pending_d;
    logic [BURST_W-1:0]   burst_q, burst_d;

    logic       ack_q, ack_d;
    logic [7:0] rdat_q, rdat_d;
    logic       err_q, err_d;
    logic [7:0] ram_adr_q, ram_adr_d;
    logic       ram_we_q, ram_we_d;
    logic [7:0] ram_wdat_q, ram_wdat_d;
    logic [6:0] sts_sel_q, sts_sel_d;
    logic       cfg_we_q, cfg_we_d;
    logic [6:0] cfg_adr_q, cfg_adr_d;
    logic [7:0] cfg_dat_q, cfg_dat_d;
    logic       wrap_q, wrap_d;
    logic       ovf_q, ovf_d;

    logic       host_win;
    logic       scan_start;
    logic       slot_end;
    logic       wr_blocked;

    // Host write to the protected upper half
`ifdef REGRAM_ARB_WPROT_EN
    assign wr_blocked = WE_i & ADR_i[7];
`else
    assign wr_blocked = 1'b0;
`endif

    // Host keeps priority until it has used its burst allowance against a pending slot
    assign host_win = REQ_i && (!pending_q || (burst_q < BURST_W'(MAX_HOST_BURST)));

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        ctr_d      = ctr_q;
        pending_d  = pending_q;
        burst_d    = burst_q;
        ack_d      = 1'b0;
        rdat_d     = rdat_q;
        err_d      = 1'b0;
        ram_adr_d  = ram_adr_q;
        ram_we_d   = 1'b0;
        ram_wdat_d = ram_wdat_q;
        sts_sel_d  = sts_sel_q;
        cfg_we_d   = 1'b0;
        cfg_adr_d  = cfg_adr_q;
        cfg_dat_d  = cfg_dat_q;
        wrap_d     = 1'b0;
        ovf_d      = ovf_q;
        scan_start = 1'b0;
        slot_end   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (host_win) begin
                    ram_adr_d = ADR_i;
                    if (pending_q) begin
                        burst_d = burst_q + BURST_W'(1);
                    end
                    if (WE_i) begin
                        state_d    = H_WR;
                        ram_wdat_d = WDAT_i;
                        ram_we_d   = !wr_blocked;
                    end else begin
                        state_d = H_RD;
                    end
                end else if (pending_q) begin
                    scan_start = 1'b1;
                    burst_d    = '0;
                    if (ctr_q[7]) begin
                        state_d   = SCAN_ST;
                        sts_sel_d = ctr_q[6:0];
                    end else begin
                        state_d   = SCAN_RD;
                        ram_adr_d = ctr_q;
                    end
                end
            end
            H_RD:  state_d = H_RDW;
            H_RDW: begin
                rdat_d  = RAM_RDAT_i;
                ack_d   = 1'b1;
                state_d = IDLE;
            end
            H_WR: begin
                ack_d   = 1'b1;
                err_d   = wr_blocked;
                state_d = IDLE;
            end
            SCAN_RD: state_d = SCAN_RDW;
            SCAN_RDW: begin
                cfg_dat_d = RAM_RDAT_i;
                cfg_adr_d = ctr_q[6:0];
                cfg_we_d  = 1'b1;
                slot_end  = 1'b1;
                state_d   = IDLE;
            end
            SCAN_ST: begin
                // Status byte for the select issued on entry is valid now
                ram_adr_d  = ctr_q;
                ram_wdat_d = STS_DAT_i;
                ram_we_d   = 1'b1;
                state_d    = SCAN_WR;
            end
            SCAN_WR: begin
                slot_end = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (slot_end) begin
            ctr_d  = ctr_q + 8'd1;
            wrap_d = (ctr_q == 8'hFF);
        end

        // A tick landing on the edge that starts the pending slot is kept, not dropped
        if (CK_EE_i && pending_q && !scan_start) begin
            ovf_d = 1'b1;
        end
        pending_d = scan_start ? CK_EE_i : (pending_q | CK_EE_i);
    end

    // State and output registers
    always_ff @(posedge CK_i or posedge ARST_i) begin
        if (ARST_i) begin
            state_q    <= IDLE;
            ctr_q      <= SCAN_BASE;
            pending_q  <= 1'b0;
            burst_q    <= '0;
            ack_q      <= 1'b0;
            rdat_q     <= '0;
            err_q      <= 1'b0;
            ram_adr_q  <= '0;
            ram_we_q   <= 1'b0;
            ram_wdat_q <= '0;
            sts_sel_q  <= '0;
            cfg_we_q   <= 1'b0;
            cfg_adr_q  <= '0;
            cfg_dat_q  <= '0;
            wrap_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctr_q      <= ctr_d;
            pending_q  <= pending_d;
            burst_q    <= burst_d;
            ack_q      <= ack_d;
            rdat_q     <= rdat_d;
            err_q      <= err_d;
            ram_adr_q  <= ram_adr_d;
            ram_we_q   <= ram_we_d;
            ram_wdat_q <= ram_wdat_d;
            sts_sel_q  <= sts_sel_d;
            cfg_we_q   <= cfg_we_d;
            cfg_adr_q  <= cfg_adr_d;
            cfg_dat_q  <= cfg_dat_d;
            wrap_q     <= wrap_d;
            ovf_q      <= ovf_d;
        end
    end

    assign ACK_o       = ack_q;
    assign RDAT_o      = rdat_q;
    assign ERR_o       = err_q;
    assign RAM_ADR_o   = ram_adr_q;
    assign RAM_WE_o    = ram_we_q;
    assign RAM_WDAT_o  = ram_wdat_q;
    assign STS_SEL_o   = sts_sel_q;
    assign CFG_WE_o    = cfg_we_q;
    assign CFG_ADR_o   = cfg_adr_q;
    assign CFG_DAT_o   = cfg_dat_q;
    assign SCAN_WRAP_o = wrap_q;
    assign SCAN_OVF_o  = ovf_q;

endmodule

// File: tb/tb_regram_arbiter.sv
// Testbench for regram_arbiter: RAM and status-bank models, scoreboard queues
// for host read data and config-bank writes.
module tb_regram_arbiter;

    localparam int unsigned MAX_BURST = 4;
    localparam logic [7:0]  SCAN_BASE = 8'h00;

    logic       CK_i   = 1'b0;
    logic       ARST_i = 1'b1;
    logic       CK_EE_i = 1'b0;
    logic       REQ_i  = 1'b0;
    logic       WE_i   = 1'b0;
    logic [7:0] ADR_i  = 8'h00;
    logic [7:0] WDAT_i = 8'h00;
    logic       ACK_o;
    logic [7:0] RDAT_o;
    logic       ERR_o;
    logic [7:0] RAM_ADR_o;
    logic       RAM_WE_o;
    logic [7:0] RAM_WDAT_o;
    logic [7:0] RAM_RDAT_i;
    logic [6:0] STS_SEL_o;
    logic [7:0] STS_DAT_i;
    logic       CFG_WE_o;
    logic [6:0] CFG_ADR_o;
    logic [7:0] CFG_DAT_o;
    logic       SCAN_WRAP_o;
    logic       SCAN_OVF_o;

    regram_arbiter #(.MAX_HOST_BURST(MAX_BURST), .SCAN_BASE(SCAN_BASE)) dut (
        .CK_i(CK_i), .ARST_i(ARST_i), .CK_EE_i(CK_EE_i),
        .REQ_i(REQ_i), .WE_i(WE_i), .ADR_i(ADR_i), .WDAT_i(WDAT_i),
        .ACK_o(ACK_o), .RDAT_o(RDAT_o), .ERR_o(ERR_o),
        .RAM_ADR_o(RAM_ADR_o), .RAM_WE_o(RAM_WE_o), .RAM_WDAT_o(RAM_WDAT_o),
        .RAM_RDAT_i(RAM_RDAT_i),
        .STS_SEL_o(STS_SEL_o), .STS_DAT_i(STS_DAT_i),
        .CFG_WE_o(CFG_WE_o), .CFG_ADR_o(CFG_ADR_o), .CFG_DAT_o(CFG_DAT_o),
        .SCAN_WRAP_o(SCAN_WRAP_o), .SCAN_OVF_o(SCAN_OVF_o)
    );

    always #5 CK_i = ~CK_i;

    // RAM model with a bench preload port
    logic [7:0] mem [256];
    logic       pre_we  = 1'b0;
    logic [7:0] pre_adr = 8'h00;
    logic [7:0] pre_dat = 8'h00;
    always @(posedge CK_i) begin
        if (pre_we) mem[pre_adr] <= pre_dat;
        else if (RAM_WE_o) mem[RAM_ADR_o] <= RAM_WDAT_o;
        RAM_RDAT_i <= mem[RAM_ADR_o];
    end

    // Status bank model: byte = ~sel
    assign STS_DAT_i = ~{1'b0, STS_SEL_o};

    int checks = 0;
    int errors = 0;
    logic [7:0]  ref_mem [256];
    logic [7:0]  rd_q  [$];
    logic [14:0] cfg_q [$];

    task automatic step;
        @(posedge CK_i);
        #1;
    endtask

    // Drives one host access and waits (bounded) for ACK_o; reports latency in edges
    task automatic host_access(input logic we, input logic [7:0] adr, input logic [7:0] wdat,
                               output logic [7:0] rdat, output int edges,
                               output logic err, output logic ok);
        REQ_i = 1'b1; WE_i = we; ADR_i = adr; WDAT_i = wdat;
        edges = 0; ok = 1'b0; rdat = 8'h00; err = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            step();
            edges++;
            if (ACK_o) begin
                ok = 1'b1; rdat = RDAT_o; err = ERR_o;
            end
        end
        REQ_i = 1'b0; WE_i = 1'b0;
    endtask

    task automatic test_reset;
        logic [51:0] outs;
        for (int i = 0; i < 256; i++) begin
            pre_we = 1'b1; pre_adr = 8'(i); pre_dat = 8'(i * 37 + 11);
            ref_mem[i] = 8'(i * 37 + 11);
            step();
        end
        pre_we = 1'b0;
        ARST_i = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            outs = {ACK_o, RDAT_o, ERR_o, RAM_ADR_o, RAM_WE_o, RAM_WDAT_o, STS_SEL_o,
                    CFG_WE_o, CFG_ADR_o, CFG_DAT_o, SCAN_WRAP_o, SCAN_OVF_o};
            checks++;
            if (outs !== '0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: outputs=%h expected 0", c, outs);
            end
        end
    endtask

    task automatic test_host;
        logic [7:0] rdat, exp;
        logic [7:0] radr [4] = '{8'h12, 8'h7F, 8'h05, 8'hC3};
        int edges;
        logic err, ok;
        host_access(1'b1, 8'h12, 8'hA5, rdat, edges, err, ok);
        ref_mem[8'h12] = 8'hA5;
        checks++;
        if (!ok || edges != 2 || err !== 1'b0) begin
            errors++;
            $display("FAIL host_wr_12: ok=%0b edges=%0d err=%0b expected ok=1 edges=2 err=0", ok, edges, err);
        end
        host_access(1'b1, 8'h7F, 8'h3C, rdat, edges, err, ok);
        ref_mem[8'h7F] = 8'h3C;
        checks++;
        if (!ok || edges != 2) begin
            errors++;
            $display("FAIL host_wr_7f: ok=%0b edges=%0d expected ok=1 edges=2", ok, edges);
        end
        foreach (radr[i]) begin
            rd_q.push_back(ref_mem[radr[i]]);
            host_access(1'b0, radr[i], 8'h00, rdat, edges, err, ok);
            exp = rd_q.pop_front();
            checks++;
            if (!ok || edges != 3 || rdat !== exp) begin
                errors++;
                $display("FAIL host_rd_%h: ok=%0b edges=%0d rdat=%h expected ok=1 edges=3 rdat=%h",
                         radr[i], ok, edges, rdat, exp);
            end
        end
        // RDAT_o holds the last read across a write
        host_access(1'b1, 8'h40, 8'h99, rdat, edges, err, ok);
        ref_mem[8'h40] = 8'h99;
        checks++;
        if (RDAT_o !== ref_mem[8'hC3]) begin
            errors++;
            $display("FAIL rdat_hold: RDAT_o=%h expected %h", RDAT_o, ref_mem[8'hC3]);
        end
    endtask

    task automatic test_scan;
        logic [7:0]  kb;
        logic [14:0] exp;
        int cfg_seen = 0, wraps = 0, we_cnt = 0;
        for (int k = 0; k < 256; k++) begin
            kb = 8'(k);
            if (!kb[7]) cfg_q.push_back({kb[6:0], ref_mem[k]});
            else ref_mem[k] = ~{1'b0, kb[6:0]};
            CK_EE_i = 1'b1;
            for (int j = 0; j < 7; j++) begin
                step();
                CK_EE_i = 1'b0;
                if (SCAN_WRAP_o) wraps++;
                if (RAM_WE_o) we_cnt++;
                if (CFG_WE_o) begin
                    cfg_seen++;
                    exp = (cfg_q.size() != 0) ? cfg_q.pop_front() : 15'h7FFF;
                    checks++;
                    if ({CFG_ADR_o, CFG_DAT_o} !== exp) begin
                        errors++;
                        $display("FAIL scan_cfg tick %0d: adr/dat=%h/%h expected %h/%h",
                                 k, CFG_ADR_o, CFG_DAT_o, exp[14:8], exp[7:0]);
                    end
                end
            end
        end
        checks++;
        if (cfg_seen != 128 || cfg_q.size() != 0) begin
            errors++;
            $display("FAIL scan_cfg_count: seen=%0d left=%0d expected 128/0", cfg_seen, cfg_q.size());
        end
        checks++;
        if (wraps != 1 || we_cnt != 128) begin
            errors++;
            $display("FAIL scan_wrap_we: wraps=%0d ram_we=%0d expected 1/128", wraps, we_cnt);
        end
        for (int i = 128; i < 256; i++) begin
            checks++;
            if (mem[i] !== ref_mem[i]) begin
                errors++;
                $display("FAIL scan_sts ram[%h]=%h expected %h", 8'(i), mem[i], ref_mem[i]);
            end
        end
        checks++;
        if (SCAN_OVF_o !== 1'b0) begin
            errors++;
            $display("FAIL scan_ovf: SCAN_OVF_o=%0b expected 0", SCAN_OVF_o);
        end
    endtask

    task automatic test_wprot;
        logic [7:0] rdat;
        int edges;
        logic err, ok, exp_err;
        host_access(1'b1, 8'h90, 8'h77, rdat, edges, err, ok);
`ifdef REGRAM_ARB_WPROT_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
        ref_mem[8'h90] = 8'h77;
`endif
        checks++;
        if (!ok || edges != 2 || err !== exp_err || mem[8'h90] !== ref_mem[8'h90]) begin
            errors++;
            $display("FAIL wprot_upper: ok=%0b edges=%0d err=%0b ram=%h expected ok=1 edges=2 err=%0b ram=%h",
                     ok, edges, err, mem[8'h90], exp_err, ref_mem[8'h90]);
        end
        step();
        checks++;
        if (ERR_o !== 1'b0 || ACK_o !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse: ERR_o=%0b ACK_o=%0b expected 0/0", ERR_o, ACK_o);
        end
        host_access(1'b1, 8'h10, 8'h5E, rdat, edges, err, ok);
        ref_mem[8'h10] = 8'h5E;
        checks++;
        if (!ok || err !== 1'b0 || mem[8'h10] !== 8'h5E) begin
            errors++;
            $display("FAIL wprot_lower: ok=%0b err=%0b ram=%h expected ok=1 err=0 ram=5e", ok, err, mem[8'h10]);
        end
    endtask

    task automatic test_burst;
        int n;
        logic done, got;
        REQ_i = 1'b1; WE_i = 1'b0; ADR_i = 8'h20;
        repeat (5) step();
        for (int t = 0; t < 6; t++) begin
            CK_EE_i = 1'b1;
            n = 0; done = 1'b0;
            for (int c = 0; c < 20; c++) begin
                step();
                CK_EE_i = 1'b0;
                if (!done) begin
                    if (ACK_o) n++;
                    if (CFG_WE_o) done = 1'b1;
                end
            end
            // One access may already be in flight when the tick lands
            checks++;
            if (!done || n < MAX_BURST || n > MAX_BURST + 1) begin
                errors++;
                $display("FAIL burst tick %0d: slot=%0b acks=%0d expected slot=1 acks %0d..%0d",
                         t, done, n, MAX_BURST, MAX_BURST + 1);
            end
        end
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            step();
            if (ACK_o) got = 1'b1;
        end
        REQ_i = 1'b0;
        checks++;
        if (!got || SCAN_OVF_o !== 1'b0) begin
            errors++;
            $display("FAIL burst_end: ack=%0b ovf=%0b expected 1/0", got, SCAN_OVF_o);
        end
    endtask

    task automatic test_overflow;
        logic [7:0]  exp;
        logic [14:0] cexp;
        int seen = 0;
        REQ_i = 1'b1; WE_i = 1'b0; ADR_i = 8'h12;
        rd_q.push_back(ref_mem[8'h12]);
        step();
        CK_EE_i = 1'b1;
        step();
        step();
        CK_EE_i = 1'b0;
        exp = rd_q.pop_front();
        checks++;
        if (ACK_o !== 1'b1 || RDAT_o !== exp) begin
            errors++;
            $display("FAIL ovf_host_ack: ack=%0b rdat=%h expected 1/%h", ACK_o, RDAT_o, exp);
        end
        REQ_i = 1'b0;
        checks++;
        if (SCAN_OVF_o !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: SCAN_OVF_o=%0b expected 1", SCAN_OVF_o);
        end
        cfg_q.push_back({7'd6, ref_mem[6]});
        for (int c = 0; c < 8; c++) begin
            step();
            if (CFG_WE_o) begin
                seen++;
                cexp = (cfg_q.size() != 0) ? cfg_q.pop_front() : 15'h7FFF;
                checks++;
                if ({CFG_ADR_o, CFG_DAT_o} !== cexp) begin
                    errors++;
                    $display("FAIL ovf_slot_cfg: %h/%h expected %h/%h", CFG_ADR_o, CFG_DAT_o, cexp[14:8], cexp[7:0]);
                end
            end
        end
        checks++;
        if (seen != 1 || SCAN_OVF_o !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: slots=%0d ovf=%0b expected 1/1", seen, SCAN_OVF_o);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0]  rdat;
        logic [14:0] cexp;
        int edges, seen, acks;
        logic err, ok;
        // Reset while the read sits in H_RDW
        REQ_i = 1'b1; WE_i = 1'b0; ADR_i = 8'h12;
        step();
        step();
        ARST_i = 1'b1;
        REQ_i = 1'b0;
        #1;
        acks = 0;
        if (ACK_o) acks++;
        repeat (2) begin
            step();
            if (ACK_o) acks++;
        end
        checks++;
        if (acks != 0 || SCAN_OVF_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_read: acks=%0d ovf=%0b expected 0/0", acks, SCAN_OVF_o);
        end
        ARST_i = 1'b0;
        step();
        // Reset while a write sits in H_WR
        REQ_i = 1'b1; WE_i = 1'b1; ADR_i = 8'h33; WDAT_i = 8'hEE;
        step();
        ARST_i = 1'b1;
        REQ_i = 1'b0; WE_i = 1'b0;
        step();
        step();
        ARST_i = 1'b0;
        checks++;
        if (mem[8'h33] !== ref_mem[8'h33]) begin
            errors++;
            $display("FAIL rst_mid_write: ram[33]=%h expected %h", mem[8'h33], ref_mem[8'h33]);
        end
        // Scan counter restarts at SCAN_BASE
        cfg_q.push_back({SCAN_BASE[6:0], ref_mem[SCAN_BASE]});
        CK_EE_i = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            CK_EE_i = 1'b0;
            if (CFG_WE_o) begin
                seen++;
                cexp = (cfg_q.size() != 0) ? cfg_q.pop_front() : 15'h7FFF;
                checks++;
                if ({CFG_ADR_o, CFG_DAT_o} !== cexp) begin
                    errors++;
                    $display("FAIL rst_ctr_base: %h/%h expected %h/%h", CFG_ADR_o, CFG_DAT_o, cexp[14:8], cexp[7:0]);
                end
            end
        end
        checks++;
        if (seen != 1) begin
            errors++;
            $display("FAIL rst_slot_count: slots=%0d expected 1", seen);
        end
        rd_q.push_back(ref_mem[8'h12]);
        host_access(1'b0, 8'h12, 8'h00, rdat, edges, err, ok);
        checks++;
        if (!ok || edges != 3 || rdat !== rd_q.pop_front()) begin
            errors++;
            $display("FAIL rst_reissue: ok=%0b edges=%0d rdat=%h expected ok=1 edges=3 rdat=%h",
                     ok, edges, rdat, ref_mem[8'h12]);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_host();
        test_scan();
        test_wprot();
        test_burst();
        test_overflow();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
